sfx_tone_decoder: RTL and testbench

- Decodes the 1-bit square-wave `sound` line driven by the sound-effect generator back into discrete tone reports.
- Each report carries an effect class, a half-period and a burst span, delivered over a valid/ack handshake.
- Sits beside the audio pin as an on-chip monitor for the scoreboard/debug logic and the self-check bench.
- Classifies purely by measured half-period and burst length; no side-channel from the generator.

---
 rtl/sfx_pkg.sv | 51 +++++
 rtl/sfx_tone_decoder_edge_sync.sv | 41 ++++
 rtl/sfx_tone_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_sfx_tone_decoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg -- shared definitions for the sound-effect tone decoder slice.
//
// Contents:
//   - tone_id_t    : report class codes carried on tone_id
//   - dec_state_t  : burst tracker states. A pending report is a flag
//                    (tone_valid), not a state, so tracking continues
//                    while a report waits for its ack.
//   - NOM_*        : nominal half-periods of the generator's tones, in cycles
//   - HP_W/SPAN_W/CNT_W : widths of half-period, burst span and edge count
//   - abs_diff19, span_sat_add : arithmetic helpers used by the decoder
package sfx_pkg;

  localparam int HP_W   = 18;
  localparam int SPAN_W = 26;
  localparam int CNT_W  = 10;

  localparam int NOM_FRUIT     = 30001;
  localparam int NOM_BOMB_LIFE = 150001;
  localparam int NOM_HS1       = 110671;
  localparam int NOM_HS2       = 82910;

  typedef enum logic [2:0] {
    TONE_UNKNOWN = 3'd0,
    TONE_FRUIT   = 3'd1,
    TONE_BOMB    = 3'd2,
    TONE_LIFE    = 3'd3,
    TONE_HS1     = 3'd4,
    TONE_HS2     = 3'd5
  } tone_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_TRACK = 2'd2
  } dec_state_t;

  // |a - b| on 19-bit operands (one bit wider than a half-period).
  function automatic logic [HP_W:0] abs_diff19(input logic [HP_W:0] a,
                                               input logic [HP_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Span accumulation; sticks at all-ones instead of wrapping.
  function automatic logic [SPAN_W-1:0] span_sat_add(input logic [SPAN_W-1:0] a,
                                                     input logic [HP_W:0]     b);
    logic [SPAN_W:0] sum;
    sum = {1'b0, a} + {{(SPAN_W - HP_W){1'b0}}, b};
    return sum[SPAN_W] ? '1 : sum[SPAN_W-1:0];
  endfunction

endpackage

// File: rtl/sfx_tone_decoder_edge_sync.sv
// sfx_edge_sync -- synchroniser plus single-cycle change flag for an
// asynchronous 1-bit line.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset; clears every flop
//   din       in   asynchronous input line
//   edge_flag out  high for one cycle after the synchronised value changes
//                  (3 clk edges after din changes)
module sfx_edge_sync
  import sfx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic edge_flag
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;
  logic              edge_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      // prev_reg holds the last synchronised value so a change of either
      // polarity shows up as a mismatch.
      prev_reg <= sync_reg[STAGES-1];
      edge_reg <= sync_reg[STAGES-1] ^ prev_reg;
    end
  end

  assign edge_flag = edge_reg;

endmodule

// File: rtl/sfx_tone_decoder.sv
// sfx_tone_decoder -- measures the generator's square-wave sound line and
// reports each tone burst (class, locked half-period, span, edge count)
// over a valid/ack handshake.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   synchronous active-low reset
//   sound        in   square-wave line, asynchronous to clk
//   tone_ack     in   consumer accepts the pending report
//   tone_valid   out  report pending, held until acked
//   tone_id      out  tone_id_t code of the report
//   half_period  out  locked half-period in cycles
//   burst_span   out  cycles first-to-last edge, saturating
//   edge_count   out  edges in burst, saturating at 1023
//   overrun      out  sticky: a completed burst was dropped while pending
//   tone_total   out  (SFX_DEC_STATS_EN only) published + dropped reports
//   glitch_total out  (SFX_DEC_STATS_EN only) discarded bursts
//
// Build option: define SFX_DEC_STATS_EN to add the two statistics counters.
// NOM_*_HP parameters default to the generator's nominal half-periods and
// let the classifier be retargeted to a differently clocked generator.
module sfx_tone_decoder
  import sfx_pkg::*;
#(
  parameter int TOL          = 64,
  parameter int TIMEOUT      = 200000,
  parameter int MIN_EDGES    = 4,
  parameter int LONG_SPAN    = 18000000,
  parameter int NOM_FRUIT_HP = NOM_FRUIT,
  parameter int NOM_BOMB_HP  = NOM_BOMB_LIFE,
  parameter int NOM_HS1_HP   = NOM_HS1,
  parameter int NOM_HS2_HP   = NOM_HS2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sound,
  input  logic              tone_ack,
  output logic              tone_valid,
  output logic [2:0]        tone_id,
  output logic [HP_W-1:0]   half_period,
  output logic [SPAN_W-1:0] burst_span,
  output logic [CNT_W-1:0]  edge_count,
`ifdef SFX_DEC_STATS_EN
  output logic [15:0]       tone_total,
  output logic [15:0]       glitch_total,
`endif
  output logic              overrun
);

  // Nominal table, index order matches the classification priority.
  localparam logic [4*HP_W-1:0] NOM_VEC = {HP_W'(NOM_HS2_HP), HP_W'(NOM_HS1_HP),
                                           HP_W'(NOM_BOMB_HP), HP_W'(NOM_FRUIT_HP)};

  logic              edge_flag;
  dec_state_t        state_reg, state_next;
  logic [HP_W-1:0]   ivl_cnt_reg;
  logic [HP_W-1:0]   lock_reg, lock_next;
  logic [CNT_W-1:0]  ecnt_reg, ecnt_next;
  logic [SPAN_W-1:0] span_reg, span_next;
  logic [HP_W:0]     interval;
  logic [HP_W:0]     lock_diff;
  logic              timeout;
  logic              close;
  logic              keep;
  logic              retire;
  logic [3:0]        nom_hit;
  tone_id_t          class_id;

  logic              tone_valid_reg;
  logic [2:0]        tone_id_reg;
  logic [HP_W-1:0]   hp_out_reg;
  logic [SPAN_W-1:0] span_out_reg;
  logic [CNT_W-1:0]  ecnt_out_reg;
  logic              overrun_reg;

  sfx_edge_sync #(.STAGES(2)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .din       (sound),
    .edge_flag (edge_flag)
  );

  // Counter holds cycles since the last edge minus one, so the interval
  // seen on an edge is the full edge-to-edge distance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ivl_cnt_reg <= '0;
    end else if (edge_flag) begin
      ivl_cnt_reg <= '0;
    end else if (ivl_cnt_reg != HP_W'(TIMEOUT)) begin
      ivl_cnt_reg <= ivl_cnt_reg + HP_W'(1);
    end
  end

  assign interval  = {1'b0, ivl_cnt_reg} + (HP_W+1)'(1);
  assign lock_diff = abs_diff19(interval, {1'b0, lock_reg});
  assign timeout   = (state_reg != ST_IDLE) && (ivl_cnt_reg == HP_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      lock_reg  <= '0;
      ecnt_reg  <= '0;
      span_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lock_reg  <= lock_next;
      ecnt_reg  <= ecnt_next;
      span_reg  <= span_next;
    end
  end

  // close reports the burst held in the *current* registers; the same cycle
  // may already load the first values of the following burst.
  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    ecnt_next  = ecnt_reg;
    span_next  = span_reg;
    close      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (edge_flag) begin
          state_next = ST_FIRST;
          ecnt_next  = CNT_W'(1);
          span_next  = '0;
        end
      end
      ST_FIRST, ST_TRACK: begin
        if (timeout) begin
          close      = 1'b1;
          state_next = ST_IDLE;
          if (edge_flag) begin
            state_next = ST_FIRST;
            ecnt_next  = CNT_W'(1);
            span_next  = '0;
          end
        end else if (edge_flag) begin
          if (state_reg == ST_FIRST || lock_diff > (HP_W+1)'(TOL)) begin
            // Second edge of a burst, or a frequency change: the new burst
            // starts at the previous edge, so it already has two edges.
            close      = (state_reg == ST_TRACK);
            state_next = ST_TRACK;
            lock_next  = interval[HP_W-1:0];
            ecnt_next  = CNT_W'(2);
            span_next  = span_sat_add('0, interval);
          end else begin
            ecnt_next = (ecnt_reg == '1) ? ecnt_reg : ecnt_reg + CNT_W'(1);
            span_next = span_sat_add(span_reg, interval);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nom
      assign nom_hit[gi] = abs_diff19({1'b0, lock_reg},
                                      {1'b0, NOM_VEC[gi*HP_W +: HP_W]}) <= (HP_W+1)'(TOL);
    end
  endgenerate

  always_comb begin
    class_id = TONE_UNKNOWN;
    if (nom_hit[0])      class_id = TONE_FRUIT;
    else if (nom_hit[1]) class_id = (span_reg >= SPAN_W'(LONG_SPAN)) ? TONE_BOMB : TONE_LIFE;
    else if (nom_hit[2]) class_id = TONE_HS1;
    else if (nom_hit[3]) class_id = TONE_HS2;
  end

  assign keep   = close && (ecnt_reg >= CNT_W'(MIN_EDGES));
  assign retire = tone_valid_reg && tone_ack;

  // overrun can only be set while a report is pending, so loading into an
  // empty or just-retired slot always leaves it clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tone_valid_reg <= 1'b0;
      tone_id_reg    <= '0;
      hp_out_reg     <= '0;
      span_out_reg   <= '0;
      ecnt_out_reg   <= '0;
      overrun_reg    <= 1'b0;
    end else if (keep && (!tone_valid_reg || retire)) begin
      tone_valid_reg <= 1'b1;
      tone_id_reg    <= class_id;
      hp_out_reg     <= lock_reg;
      span_out_reg   <= span_reg;
      ecnt_out_reg   <= ecnt_reg;
      overrun_reg    <= 1'b0;
    end else if (keep) begin
      overrun_reg <= 1'b1;
    end else if (retire) begin
      tone_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end
  end

  assign tone_valid  = tone_valid_reg;
  assign tone_id     = tone_id_reg;
  assign half_period = hp_out_reg;
  assign burst_span  = span_out_reg;
  assign edge_count  = ecnt_out_reg;
  assign overrun     = overrun_reg;

`ifdef SFX_DEC_STATS_EN
  logic [15:0] tone_total_reg;
  logic [15:0] glitch_total_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tone_total_reg   <= '0;
      glitch_total_reg <= '0;
    end else begin
      if (keep && tone_total_reg != '1)
        tone_total_reg <= tone_total_reg + 16'd1;
      if (close && !keep && glitch_total_reg != '1)
        glitch_total_reg <= glitch_total_reg + 16'd1;
    end
  end

  assign tone_total   = tone_total_reg;
  assign glitch_total = glitch_total_reg;
`endif

endmodule

// File: tb/tb_sfx_tone_decoder.sv
// tb_sfx_tone_decoder -- self-checking bench for sfx_tone_decoder.
// Runs the decoder with scaled-down timing (nominal half-periods of tens of
// cycles) and compares every cycle against a model that keeps the edge times
// of the current burst and derives count, span and lock from them.
module tb_sfx_tone_decoder;

  localparam int TOL  = 4;
  localparam int TMO  = 200;
  localparam int MINE = 4;
  localparam int LONG = 6000;
  localparam int NF   = 30;
  localparam int NB   = 150;
  localparam int NH1  = 110;
  localparam int NH2  = 82;
  localparam int SPAN_MAX = (1 << 26) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sound = 1'b0;
  logic        tone_ack = 1'b0;
  logic        tone_valid;
  logic [2:0]  tone_id;
  logic [17:0] half_period;
  logic [25:0] burst_span;
  logic [9:0]  edge_count;
  logic        overrun;
`ifdef SFX_DEC_STATS_EN
  logic [15:0] tone_total;
  logic [15:0] glitch_total;
`endif

  sfx_tone_decoder #(
    .TOL(TOL), .TIMEOUT(TMO), .MIN_EDGES(MINE), .LONG_SPAN(LONG),
    .NOM_FRUIT_HP(NF), .NOM_BOMB_HP(NB), .NOM_HS1_HP(NH1), .NOM_HS2_HP(NH2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sound(sound), .tone_ack(tone_ack),
    .tone_valid(tone_valid), .tone_id(tone_id), .half_period(half_period),
    .burst_span(burst_span), .edge_count(edge_count),
`ifdef SFX_DEC_STATS_EN
    .tone_total(tone_total), .glitch_total(glitch_total),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int hp; int span; int cnt; } rep_t;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   due_q[$];     // cycles at which pin toggles reach the tracker
  int   be_q[$];      // edge times of the burst being tracked
  int   lock_m = 0;
  bit   m_valid = 0;
  bit   m_over = 0;
  rep_t m_rep = '{0, 0, 0, 0};
  int   m_tones = 0;
  int   m_glitch = 0;
  bit   hold_ack = 1;
  bit   ack_req = 0;
  bit   prev_rst = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
      if (errors >= 100) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int classify(input int hp, input int span);
    if (iabs(hp - NF)  <= TOL) return 1;
    if (iabs(hp - NB)  <= TOL) return (span >= LONG) ? 2 : 3;
    if (iabs(hp - NH1) <= TOL) return 4;
    if (iabs(hp - NH2) <= TOL) return 5;
    return 0;
  endfunction

  task automatic close_burst(output bit have, output rep_t r);
    int n;
    n = be_q.size();
    have = 0;
    r = '{0, 0, 0, 0};
    if (n < MINE) begin
      if (m_glitch < 65535) m_glitch++;
    end else begin
      have   = 1;
      r.hp   = lock_m;
      r.span = be_q[n-1] - be_q[0];
      if (r.span > SPAN_MAX) r.span = SPAN_MAX;
      r.cnt  = (n > 1023) ? 1023 : n;
      r.id   = classify(r.hp, r.span);
      if (m_tones < 65535) m_tones++;
    end
  endtask

  task automatic model_update(input bit rst, input bit tog, input bit ack);
    bit   edge_now;
    bit   have;
    bit   retire;
    rep_t r;
    int   iv;
    int   last;
    have = 0;
    r = '{0, 0, 0, 0};
    if (rst) begin
      due_q.delete();
      be_q.delete();
      lock_m = 0; m_valid = 0; m_over = 0; m_rep = '{0, 0, 0, 0};
      m_tones = 0; m_glitch = 0;
      return;
    end
    if (tog) due_q.push_back(cyc + 3);
    edge_now = 0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      edge_now = 1;
      void'(due_q.pop_front());
    end
    if (be_q.size() > 0 && cyc - be_q[be_q.size()-1] == TMO + 1) begin
      close_burst(have, r);
      be_q.delete();
    end
    if (edge_now) begin
      if (be_q.size() == 0) begin
        be_q.push_back(cyc);
      end else if (be_q.size() == 1) begin
        lock_m = cyc - be_q[0];
        be_q.push_back(cyc);
      end else begin
        last = be_q[be_q.size()-1];
        iv = cyc - last;
        if (iabs(iv - lock_m) <= TOL) begin
          be_q.push_back(cyc);
        end else begin
          close_burst(have, r);
          be_q.delete();
          be_q.push_back(last);
          be_q.push_back(cyc);
          lock_m = iv;
        end
      end
    end
    retire = ack && m_valid;
    if (have) begin
      if (!m_valid || retire) begin
        m_rep = r; m_valid = 1; m_over = 0;
      end else begin
        m_over = 1;
      end
    end else if (retire) begin
      m_valid = 0; m_over = 0;
    end
  endtask

  task automatic compare_cycle(input bit rst);
    check("tone_valid", tone_valid, m_valid);
    check("overrun", overrun, m_over);
    if (m_valid) begin
      check("tone_id", tone_id, m_rep.id);
      check("half_period", half_period, m_rep.hp);
      check("burst_span", burst_span, m_rep.span);
      check("edge_count", edge_count, m_rep.cnt);
    end
    if (rst || prev_rst) begin
      check("reset_payload", {tone_id, half_period, burst_span, edge_count}, 64'd0);
    end
`ifdef SFX_DEC_STATS_EN
    check("tone_total", tone_total, m_tones);
    check("glitch_total", glitch_total, m_glitch);
`endif
  endtask

  task automatic step(input bit tog, input bit rst);
    bit ack;
    ack = ack_req;
    ack_req = 0;
    if (!hold_ack && $urandom_range(0, 7) == 0) ack = 1;
    tone_ack = ack;
    reset_n = ~rst;
    if (tog) sound = ~sound;
    @(posedge clk);
    cyc++;
    model_update(rst, tog, ack);
    #1;
    compare_cycle(rst);
    prev_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic burst(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle(p - 1);
      step(1, 0);
    end
  endtask

  task automatic burst_j(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle(base - 3 + $urandom_range(0, 4));
      step(1, 0);
    end
  endtask

  task automatic expect_report(input string nm, input int id, input int hp,
                               input int span, input int cnt);
    int waited;
    waited = 0;
    while (tone_valid !== 1'b1 && waited < 1000) begin
      step(0, 0);
      waited++;
    end
    check({nm, ".valid"}, tone_valid, 1);
    check({nm, ".id"}, tone_id, id);
    check({nm, ".half_period"}, half_period, hp);
    check({nm, ".span"}, burst_span, span);
    check({nm, ".count"}, edge_count, cnt);
    ack_req = 1;
    step(0, 0);
    check({nm, ".acked"}, tone_valid, 0);
  endtask

  initial begin
    int bases[6];
    bases = '{NF, NB, NH1, NH2, 55, 180};

    for (int i = 0; i < 4; i++) step(0, 1);
    idle(4);

    // Long FRUIT burst.
    burst(NF, 216); idle(TMO + 10);
    expect_report("fruit", 1, 30, 215 * 30, 216);

    // BOMB/LIFE split exactly at the span threshold.
    burst(NB, 41); idle(TMO + 10);
    expect_report("bomb", 2, 150, 6000, 41);
    burst(NB, 40); idle(TMO + 10);
    expect_report("life", 3, 150, 5850, 40);

    // HS1 straight into HS2; HS2 inherits the last HS1 edge.
    burst(NH1, 40); idle(NH2 - 1); burst(NH2, 60);
    expect_report("hs1", 4, 110, 39 * 110, 40);
    idle(TMO + 10);
    expect_report("hs2", 5, 82, 60 * 82, 61);

    // Too few edges: discarded.
    burst(NF, 3); idle(TMO + 10);
    check("glitch.no_report", tone_valid, 0);

    // Second burst completes while the first is unacked.
    burst(NF, 10); idle(TMO + 10);
    burst(NH1, 8); idle(TMO + 10);
    check("ovr.flag", overrun, 1);
    expect_report("ovr_first", 1, 30, 270, 10);
    check("ovr.cleared", overrun, 0);

    // Ack with nothing pending is ignored.
    ack_req = 1; step(0, 0);
    check("stray_ack", tone_valid, 0);

    // Close and ack in the same cycle: old retires, new loads, no overrun.
    burst(NF, 6); idle(TMO + 10);
    burst(NH2, 6); idle(TMO + 3);
    ack_req = 1; step(0, 0);
    check("swap.valid", tone_valid, 1);
    check("swap.overrun", overrun, 0);
    check("swap.id", tone_id, 5);
    check("swap.span", burst_span, 5 * 82);
    check("swap.count", edge_count, 6);
    ack_req = 1; step(0, 0);

    // Reset mid-burst; only the later clean burst is reported.
    if (sound) begin step(1, 0); idle(TMO + 10); end
    burst(NF, 10); idle(5);
    step(0, 1);
    check("rst.valid", tone_valid, 0);
    idle(TMO + 10);
    check("rst.no_report", tone_valid, 0);
    burst(NF, 20); idle(TMO + 10);
    expect_report("after_rst", 1, 30, 19 * 30, 20);

    // Randomised segments with jitter, back-to-back changes and random acks.
    hold_ack = 0;
    for (int s = 0; s < 12; s++) begin
      int b;
      b = bases[$urandom_range(0, 5)];
      burst_j(b, $urandom_range(2, 16));
      if ($urandom_range(0, 1) == 1) idle(TMO + 10);
      else idle(b - 1);
    end
    idle(TMO + 10);
    for (int i = 0; i < 500 && m_valid; i++) step(0, 0);
    hold_ack = 1;
    check("drain", tone_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
